// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared period, clock prescaler and a
// double-buffered duty/period/prescale set that swaps only at a
// period boundary, so the outputs never glitch.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en_out          per-channel output enable (live)
//   en_pwm          per-channel 1=PWM, 0=static high level (live)
//   polarity        per-channel output inversion (live)
//   duty_in         flattened duties, channel i at [i*CNT_W +: CNT_W]
//   period_in       counter top value (counter runs 0..period)
//   prescale_in     prescaler top (tick every prescale+1 clocks)
//   cfg_commit      strobe: capture duty/period/prescale into shadow
//   out             registered channel outputs
//   period_start    pulse on the first output cycle of each period
//   commit_pending  shadow loaded, not yet transferred to active
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  input  logic [NUM_CH-1:0]         polarity,
  input  logic [NUM_CH*CNT_W-1:0]   duty_in,
  input  logic [CNT_W-1:0]          period_in,
  input  logic [DIV_W-1:0]          prescale_in,
  input  logic                      cfg_commit,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_start,
  output logic                      commit_pending
);

  localparam int DW = NUM_CH * CNT_W;

  logic [DIV_W-1:0]  pre_cnt;
  logic [DIV_W-1:0]  prescale_act;
  logic [DIV_W-1:0]  prescale_sh;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  period_sh;
  logic [DW-1:0]     duty_act;
  logic [DW-1:0]     duty_sh;

  logic              tick;
  logic              boundary;
  logic              xfer;
  logic [DIV_W-1:0]  pre_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  period_nxt;
  logic [DW-1:0]     duty_nxt;
  logic [NUM_CH-1:0] out_nxt;

  // Counter and active-set state as they will be after this edge.
  always_comb begin
    tick       = (pre_cnt == prescale_act);
    boundary   = tick && (cnt == period_act);
    xfer       = boundary && commit_pending;
    pre_nxt    = tick ? '0 : pre_cnt + 1'b1;
    cnt_nxt    = cnt;
    if (tick)
      cnt_nxt  = (cnt == period_act) ? '0 : cnt + 1'b1;
    period_nxt = xfer ? period_sh : period_act;
    duty_nxt   = xfer ? duty_sh : duty_act;
  end

  // The output register is fed from the next-state counter and set,
  // so `out` always shows the compare for the cnt value held in the
  // same cycle; the first cnt=0 cycle coincides with period_start.
  always_comb begin
    logic [CNT_W-1:0] d;
    logic             raw;
    out_nxt = '0;
    d       = '0;
    raw     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      d   = duty_nxt[i*CNT_W +: CNT_W];
      raw = (cnt_nxt < d) || (d > period_nxt);
      if (en_out[i])
        out_nxt[i] = (en_pwm[i] ? raw : 1'b1) ^ polarity[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt        <= '0;
      cnt            <= '0;
      prescale_act   <= '0;
      period_act     <= '1;
      duty_act       <= '0;
      prescale_sh    <= '0;
      period_sh      <= '1;
      duty_sh        <= '0;
      commit_pending <= 1'b0;
      out            <= '0;
      period_start   <= 1'b0;
    end else begin
      pre_cnt      <= pre_nxt;
      cnt          <= cnt_nxt;
      period_act   <= period_nxt;
      duty_act     <= duty_nxt;
      out          <= out_nxt;
      period_start <= boundary;
      if (xfer) begin
        prescale_act   <= prescale_sh;
        commit_pending <= 1'b0;
      end
      // A commit in the boundary cycle lands in the shadow after the
      // old shadow has moved to active, and stays pending.
      if (cfg_commit) begin
        duty_sh        <= duty_in;
        period_sh      <= period_in;
        prescale_sh    <= prescale_in;
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: cycle model feeding a scoreboard queue
// plus directed period/duty measurements.
module tb_pwm_multi_channel;

  localparam int NC = 16;
  localparam int CW = 8;
  localparam int DV = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    en_out = 16'h0001;
  logic [NC-1:0]    en_pwm = 16'h0001;
  logic [NC-1:0]    polarity = '0;
  logic [NC*CW-1:0] duty_in = '0;
  logic [CW-1:0]    period_in = '0;
  logic [DV-1:0]    prescale_in = '0;
  logic             cfg_commit = 1'b0;
  logic [NC-1:0]    out;
  logic             period_start;
  logic             commit_pending;

  pwm_multi_channel #(.NUM_CH(NC), .CNT_W(CW), .DIV_W(DV)) dut (
    .clk(clk), .rst(rst),
    .en_out(en_out), .en_pwm(en_pwm), .polarity(polarity),
    .duty_in(duty_in), .period_in(period_in),
    .prescale_in(prescale_in), .cfg_commit(cfg_commit),
    .out(out), .period_start(period_start),
    .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [NC+1:0] sb_q[$];

  // model state
  int m_pre, m_cnt, m_period, m_prescale, m_pend;
  int m_duty[NC];
  int s_period, s_prescale;
  int s_duty[NC];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(output logic [NC+1:0] e);
    logic [NC-1:0] o;
    bit tk, bnd, raw;
    o = '0;
    e = '0;
    if (rst) begin
      m_pre = 0; m_cnt = 0; m_pend = 0;
      m_period = 255; m_prescale = 0;
      s_period = 255; s_prescale = 0;
      for (int i = 0; i < NC; i++) begin
        m_duty[i] = 0;
        s_duty[i] = 0;
      end
      return;
    end
    tk  = (m_pre == m_prescale);
    bnd = tk && (m_cnt == m_period);
    if (bnd && m_pend != 0) begin
      m_period = s_period;
      m_prescale = s_prescale;
      for (int i = 0; i < NC; i++) m_duty[i] = s_duty[i];
      m_pre = 0; m_cnt = 0; m_pend = 0;
    end else if (tk) begin
      m_pre = 0;
      m_cnt = bnd ? 0 : m_cnt + 1;
    end else begin
      m_pre++;
    end
    if (cfg_commit) begin
      s_period = period_in;
      s_prescale = prescale_in;
      for (int i = 0; i < NC; i++) s_duty[i] = duty_in[i*CW +: CW];
      m_pend = 1;
    end
    for (int i = 0; i < NC; i++) begin
      raw = (m_cnt < m_duty[i]) || (m_duty[i] > m_period);
      if (en_out[i]) o[i] = (en_pwm[i] ? raw : 1'b1) ^ polarity[i];
    end
    e = {o, bnd, m_pend[0]};
  endtask

  task automatic cyc();
    logic [NC+1:0] e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("cyc", {14'd0, out, period_start, commit_pending}, {14'd0, e});
  endtask

  task automatic commit(int d0, int per, int pre);
    duty_in[7:0] = d0[7:0];
    period_in = per[7:0];
    prescale_in = pre[7:0];
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < 600);
    check("ps_wait", {31'd0, period_start}, 32'd1);
  endtask

  // called in a period_start cycle; measures that period
  task automatic measure(output int len, output int highs);
    highs = out[0];
    len = 0;
    while (len < 600) begin
      cyc();
      len++;
      if (period_start) break;
      highs += out[0];
    end
  endtask

  initial begin
    int len, hi, n;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_pend", {31'd0, commit_pending}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);

    hi = 0;
    repeat (600) begin
      cyc();
      if (out != 0) hi++;
    end
    check("idle_out", hi, 0);
    check("idle_pend", {31'd0, commit_pending}, 32'd0);

    commit(3, 9, 0);
    check("pend_set", {31'd0, commit_pending}, 32'd1);
    wait_ps();
    measure(len, hi);
    check("p9_len", len, 10);
    check("p9_high", hi, 3);
    measure(len, hi);
    check("p9_len2", len, 10);
    check("p9_high2", hi, 3);

    commit(10, 9, 1);
    wait_ps();
    measure(len, hi);
    check("full_len", len, 20);
    check("full_high", hi, 20);
    commit(0, 9, 1);
    wait_ps();
    measure(len, hi);
    check("zero_len", len, 20);
    check("zero_high", hi, 0);

    commit(2, 9, 0);
    wait_ps();
    repeat (3) cyc();
    commit(5, 9, 0);
    repeat (2) cyc();
    commit(7, 9, 0);
    wait_ps();
    measure(len, hi);
    check("ovr_len", len, 10);
    check("ovr_high", hi, 7);

    en_pwm[1] = 1'b0;
    en_out[1] = 1'b1;
    polarity[1] = 1'b1;
    cyc();
    check("st_inv", {31'd0, out[1]}, 32'd0);
    polarity[1] = 1'b0;
    cyc();
    check("st_hi", {31'd0, out[1]}, 32'd1);
    en_out[1] = 1'b0;
    cyc();
    check("dis0", {31'd0, out[1]}, 32'd0);
    polarity[1] = 1'b1;
    cyc();
    check("dis1", {31'd0, out[1]}, 32'd0);

    n = 0;
    while (!(m_pre == m_prescale && m_cnt == m_period) && n < 100) begin
      cyc();
      n++;
    end
    commit(4, 9, 0);
    check("bc_ps", {31'd0, period_start}, 32'd1);
    check("bc_pend", {31'd0, commit_pending}, 32'd1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (period_start) break;
      if (commit_pending) n++;
    end
    check("bc_hold", n, 9);
    check("bc_clr", {31'd0, commit_pending}, 32'd0);
    measure(len, hi);
    check("bc_high", hi, 4);

    repeat (3) cyc();
    commit(6, 9, 0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    check("mrst_out", {16'd0, out}, 32'd0);
    check("mrst_pend", {31'd0, commit_pending}, 32'd0);
    cyc();
    rst = 1'b0;
    wait_ps();
    measure(len, hi);
    check("mrst_len", len, 256);
    check("mrst_high", hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
